// File: rtl/mod503_chunk_accum_if.sv
`default_nettype none
// ============================================================================
// Module   : mod503_chunk_accum_if
// Purpose  : Stream bundle for mod503_chunk_accum. It carries the partial
//            residue input stream (valid/ready/last) and the frame result
//            output stream (valid/ready plus result fields).
// Ports    : none. Parameters W (residue width) and NCHUNK (max beats).
// Modports : master - upstream producer / result consumer side
//            slave  - the accumulator itself
// Options  : MOD503_RANGE_CHECK_EN adds out_range_err to the bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface mod503_chunk_accum_if #(
  parameter int W      = 9,
  parameter int NCHUNK = 4
) ();
  localparam int BW = $clog2(NCHUNK + 1);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_residue;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_residue;
  logic          out_overrun;
  logic [BW-1:0] out_beats;
`ifdef MOD503_RANGE_CHECK_EN
  logic          out_range_err;
`endif

  modport master (
    output in_valid, in_residue, in_last, out_ready,
    input  in_ready, out_valid, out_residue, out_overrun,
`ifdef MOD503_RANGE_CHECK_EN
    input  out_range_err,
`endif
    input  out_beats
  );

  modport slave (
    input  in_valid, in_residue, in_last, out_ready,
    output in_ready, out_valid, out_residue, out_overrun,
`ifdef MOD503_RANGE_CHECK_EN
    output out_range_err,
`endif
    output out_beats
  );
endinterface
`default_nettype wire

// File: rtl/mod503_chunk_accum.sv
`default_nettype none
// ============================================================================
// Module   : mod503_chunk_accum
// Purpose  : Sums a frame of W-bit partial residues modulo MOD and presents
//            one fully reduced residue per frame. A frame closes on in_last
//            or is force-closed after NCHUNK beats (flagged as overrun).
// Ports    : clk  - clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - mod503_chunk_accum_if.slave
//                   in_valid/in_ready/in_residue/in_last : beat stream
//                   out_valid/out_ready                  : result handshake
//                   out_residue  : frame sum mod MOD (< MOD)
//                   out_overrun  : frame closed at NCHUNK beats w/o in_last
//                   out_beats    : beats consumed in the reported frame
//                   out_range_err: (optional) some beat had in_residue >= MOD
// Options  : define MOD503_RANGE_CHECK_EN to enable out_range_err.
// Revision : 1.0 - initial release
// ============================================================================
module mod503_chunk_accum #(
  parameter int MOD    = 503,
  parameter int W      = 9,
  parameter int NCHUNK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mod503_chunk_accum_if.slave   bus
);
  localparam int BW = $clog2(NCHUNK + 1);
  localparam logic [W-1:0]  c_MOD    = W'(MOD);
  localparam logic [W:0]    c_MOD_X  = (W + 1)'(MOD);
  localparam logic [BW-1:0] c_NCHUNK = BW'(NCHUNK);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_acc;
  logic [BW-1:0] r_count;
  logic          r_out_valid;
  logic [W-1:0]  r_out_residue;
  logic          r_out_overrun;
  logic [BW-1:0] r_out_beats;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_hi;
  logic [W-1:0]  w_r;
  logic [W-1:0]  w_base_acc;
  logic [BW-1:0] w_base_cnt;
  logic [W:0]    w_sum;
  logic [W-1:0]  w_acc_next;
  logic [BW-1:0] w_cnt_next;
  logic          w_close;

  assign w_in_ready = !r_out_valid | bus.out_ready;
  assign w_accept   = bus.in_valid & w_in_ready;

  // The modulus exceeds 2^(W-1), so one conditional subtract fully reduces any W-bit input.
  assign w_hi = (bus.in_residue >= c_MOD);
  assign w_r  = w_hi ? (bus.in_residue - c_MOD) : bus.in_residue;

  // Only ACC continues a frame; a beat taken in IDLE or DONE (simultaneous
  // with consume) starts a fresh frame from zero.
  assign w_base_acc = (r_state == ST_ACC) ? r_acc   : '0;
  assign w_base_cnt = (r_state == ST_ACC) ? r_count : '0;

  // Both operands < MOD, so the W+1-bit sum needs at most one subtract.
  assign w_sum      = {1'b0, w_base_acc} + {1'b0, w_r};
  assign w_acc_next = (w_sum >= c_MOD_X) ? W'(w_sum - c_MOD_X) : W'(w_sum);
  assign w_cnt_next = w_base_cnt + BW'(1);
  assign w_close    = bus.in_last | (w_cnt_next == c_NCHUNK);

`ifdef MOD503_RANGE_CHECK_EN
  logic r_err;
  logic r_out_err;
  logic w_err_next;
  assign w_err_next        = ((r_state == ST_ACC) & r_err) | w_hi;
  assign bus.out_range_err = r_out_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_acc         <= '0;
      r_count       <= '0;
      r_out_valid   <= 1'b0;
      r_out_residue <= '0;
      r_out_overrun <= 1'b0;
      r_out_beats   <= '0;
`ifdef MOD503_RANGE_CHECK_EN
      r_err         <= 1'b0;
      r_out_err     <= 1'b0;
`endif
    end else begin
      if (r_state == ST_DONE && bus.out_ready) begin
        r_out_valid <= 1'b0;
        r_state     <= ST_IDLE;
      end
      // A beat overrides the consume transition above when both happen.
      if (w_accept) begin
        if (w_close) begin
          r_state       <= ST_DONE;
          r_out_valid   <= 1'b1;
          r_out_residue <= w_acc_next;
          r_out_overrun <= !bus.in_last;
          r_out_beats   <= w_cnt_next;
          r_acc         <= '0;
          r_count       <= '0;
`ifdef MOD503_RANGE_CHECK_EN
          r_out_err     <= w_err_next;
          r_err         <= 1'b0;
`endif
        end else begin
          r_state <= ST_ACC;
          r_acc   <= w_acc_next;
          r_count <= w_cnt_next;
`ifdef MOD503_RANGE_CHECK_EN
          r_err   <= w_err_next;
`endif
        end
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_residue = r_out_residue;
  assign bus.out_overrun = r_out_overrun;
  assign bus.out_beats   = r_out_beats;

endmodule
`default_nettype wire

// File: tb/tb_mod503_chunk_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod503_chunk_accum
// Purpose  : Self-checking bench for mod503_chunk_accum. Directed frames with
//            hand-computed results, then randomized frames with random
//            backpressure, all checked against a frame-sum reference model.
// Options  : honours MOD503_RANGE_CHECK_EN (checks out_range_err).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod503_chunk_accum;
  localparam int MOD    = 503;
  localparam int W      = 9;
  localparam int NCHUNK = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod503_chunk_accum_if #(.W(W), .NCHUNK(NCHUNK)) bus ();

  mod503_chunk_accum #(.MOD(MOD), .W(W), .NCHUNK(NCHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + compare process ----------------
  typedef struct packed {
    logic [8:0] res;
    logic [2:0] beats;
    logic       ovr;
    logic       err;
  } exp_t;

  exp_t       q[$];
  int         m_sum = 0;
  int         m_n   = 0;
  bit         m_err = 0;
  bit         p_hold = 0;
  logic [8:0] p_res;
  logic [2:0] p_beats;
  logic       p_ovr;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_sum  = 0;
      m_n    = 0;
      m_err  = 0;
      p_hold = 0;
    end else begin
      exp_t e;
      chk("in_ready_rule", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
      if (bus.out_valid) chk("res_below_mod", int'(bus.out_residue < 9'(MOD)), 1);
      if (p_hold) begin
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_res", int'(bus.out_residue), int'(p_res));
        chk("hold_beats", int'(bus.out_beats), int'(p_beats));
        chk("hold_ovr", int'(bus.out_overrun), int'(p_ovr));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=%0d required=no_result", bus.out_residue);
        end else begin
          e = q.pop_front();
          chk("model_res", int'(bus.out_residue), int'(e.res));
          chk("model_beats", int'(bus.out_beats), int'(e.beats));
          chk("model_ovr", int'(bus.out_overrun), int'(e.ovr));
`ifdef MOD503_RANGE_CHECK_EN
          chk("model_err", int'(bus.out_range_err), int'(e.err));
`endif
        end
      end
      p_hold  = bus.out_valid && !bus.out_ready;
      p_res   = bus.out_residue;
      p_beats = bus.out_beats;
      p_ovr   = bus.out_overrun;
      // A beat visible with in_ready here is taken at the coming rising edge.
      if (bus.in_valid && bus.in_ready) begin
        m_sum += int'(bus.in_residue);
        m_n++;
        if (bus.in_residue >= 9'(MOD)) m_err = 1;
        if (bus.in_last || m_n == NCHUNK) begin
          e.res   = 9'(m_sum % MOD);
          e.beats = 3'(m_n);
          e.ovr   = !bus.in_last;
          e.err   = m_err;
          q.push_back(e);
          m_sum = 0;
          m_n   = 0;
          m_err = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit rnd_ready = 0;

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic beat(input int v, input bit last);
    bit ok;
    ok = 0;
    bus.in_valid   = 1'b1;
    bus.in_residue = 9'(v);
    bus.in_last    = last;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 1) == 1);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL beat_accept_timeout actual=no_ready required=ready");
    end
  endtask

  task automatic check_out(input string name, input int res, input int beats, input int ovr);
    chk({name, "_valid"}, int'(bus.out_valid), 1);
    chk({name, "_res"}, int'(bus.out_residue), res);
    chk({name, "_beats"}, int'(bus.out_beats), beats);
    chk({name, "_ovr"}, int'(bus.out_overrun), ovr);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len;
    bit no_last;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_residue = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_res", int'(bus.out_residue), 0);
    chk("rst_ovr", int'(bus.out_overrun), 0);
    chk("rst_beats", int'(bus.out_beats), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);

    // 1: 500+500 = 1000 mod 503 = 497
    beat(500, 0);
    chk("t1_mid_valid", int'(bus.out_valid), 0);
    beat(500, 1);
    check_out("t1", 497, 2, 0);

    // 2: 4*502 = 2008 mod 503 = 499, closed by in_last then by overrun
    beat(502, 0); beat(502, 0); beat(502, 0); beat(502, 1);
    check_out("t2_last", 499, 4, 0);
    beat(502, 0); beat(502, 0); beat(502, 0); beat(502, 0);
    check_out("t2_ovr", 499, 4, 1);
    beat(1, 1);
    check_out("t2_next", 1, 1, 0);

    // 3: 511 reduces to 8
    beat(511, 1);
    check_out("t3", 8, 1, 0);
`ifdef MOD503_RANGE_CHECK_EN
    chk("t3_err", int'(bus.out_range_err), 1);
`endif
    beat(5, 1);
    check_out("t3_next", 5, 1, 0);
`ifdef MOD503_RANGE_CHECK_EN
    chk("t3_next_err", int'(bus.out_range_err), 0);
`endif

    // 4: backpressure with a beat waiting, then consume + accept together
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    beat(500, 0);
    beat(500, 1);
    bus.in_valid   = 1'b1;
    bus.in_residue = 9'd7;
    bus.in_last    = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t4_in_ready", int'(bus.in_ready), 0);
      check_out("t4_hold", 497, 2, 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_out("t4_next", 7, 1, 0);

    // 5: reset mid-frame discards partial sum
    beat(300, 0);
    beat(300, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_valid_after_rst", int'(bus.out_valid), 0);
    beat(10, 1);
    check_out("t5", 10, 1, 0);

    // 6: randomized frames with random backpressure
    rnd_ready = 1;
    for (int f = 0; f < 250; f++) begin
      len     = $urandom_range(1, NCHUNK);
      no_last = (len == NCHUNK) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        bus.out_ready = ($urandom_range(0, 2) != 0);
        beat($urandom_range(0, 511), (i == len - 1) && !no_last);
      end
    end
    rnd_ready     = 0;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
    chk("drain_valid", int'(bus.out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
